// File: rtl/lane_packer_pkg.sv
// Shared constants and state type for the lane packer and max-reduction path.
package lane_packer_pkg;
  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = 2;
  localparam int LANE_CNT_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;
endpackage

// File: rtl/lane_packer.sv
// Serial-to-parallel packer: gathers WIDTH-bit samples into a 4-lane word,
// with early flush producing a zero-padded partial word plus lane mask.
module lane_packer
  import lane_packer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in_value,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [NUM_LANES*WIDTH-1:0] lane_values,
  output logic [NUM_LANES-1:0]       lane_mask,
  output logic [LANE_CNT_W-1:0]      lane_count,
  output logic                       out_valid,
  input  logic                       out_ready
);

  state_t                state_q;
  state_t                state_d;
  logic [LANE_IDX_W-1:0] idx_q;
  logic                  accept;
  logic                  clear;
  logic                  last_lane;

  assign in_ready  = (state_q == FILL) && !reset;
  assign accept    = in_valid && in_ready;
  assign last_lane = (idx_q == LANE_IDX_W'(NUM_LANES - 1));

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept && (last_lane || flush))
          state_d = HOLD;
        else if (flush && idx_q != '0)
          state_d = HOLD;
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          state_d = FILL;
          clear   = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      idx_q      <= '0;
      lane_count <= '0;
      out_valid  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == HOLD);
      if (clear) begin
        idx_q      <= '0;
        lane_count <= '0;
      end else if (accept) begin
        idx_q      <= idx_q + 1'b1;
        lane_count <= lane_count + 1'b1;
      end
    end
  end

  // Each lane owns its slice; only the lane under idx is written on accept.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic we;
    assign we = accept && (idx_q == LANE_IDX_W'(i));

    always_ff @(posedge clk) begin
      if (reset || clear) begin
        lane_values[i*WIDTH +: WIDTH] <= '0;
        lane_mask[i]                  <= 1'b0;
      end else if (we) begin
        lane_values[i*WIDTH +: WIDTH] <= in_value;
        lane_mask[i]                  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lane_packer.sv
// Directed self-checking bench for lane_packer with hand-computed words.
module tb_lane_packer;
  import lane_packer_pkg::*;

  localparam int W = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [W-1:0]           in_value;
  logic                   in_valid;
  logic                   in_ready;
  logic                   flush;
  logic [NUM_LANES*W-1:0] lane_values;
  logic [NUM_LANES-1:0]   lane_mask;
  logic [LANE_CNT_W-1:0]  lane_count;
  logic                   out_valid;
  logic                   out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  lane_packer #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_value   (in_value),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .lane_values(lane_values),
    .lane_mask  (lane_mask),
    .lane_count (lane_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [W-1:0] v);
    in_valid = 1'b1;
    in_value = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_word(input string tag,
                          input logic [15:0] v,
                          input logic [3:0] m,
                          input logic [2:0] c);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".values"}, 32'(lane_values), 32'(v));
    chk({tag, ".mask"}, 32'(lane_mask), 32'(m));
    chk({tag, ".count"}, 32'(lane_count), 32'(c));
  endtask

  initial begin
    reset     = 1'b1;
    in_value  = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.values", 32'(lane_values), 32'd0);
    chk("rst.mask", 32'(lane_mask), 32'd0);
    chk("rst.count", 32'(lane_count), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Full word, out_ready held high
    feed(4'h3); feed(4'h9); feed(4'h1); feed(4'h7);
    chk_word("full", 16'h7193, 4'hF, 3'd4);
    chk("full.in_ready_hold", 32'(in_ready), 32'd0);
    step();
    chk("full.valid_drop", 32'(out_valid), 32'd0);
    chk("full.in_ready_back", 32'(in_ready), 32'd1);
    chk("full.cleared", 32'(lane_values), 32'd0);

    // Backpressure: held 4 cycles, sample during HOLD not consumed
    out_ready = 1'b0;
    feed(4'h3); feed(4'h9); feed(4'h1); feed(4'h7);
    in_valid = 1'b1;
    in_value = 4'h8;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) out_ready = 1'b1;
      chk_word("bp", 16'h7193, 4'hF, 3'd4);
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      if (i < 3) step();
    end
    step();
    in_valid = 1'b0;
    chk("bp.valid_drop", 32'(out_valid), 32'd0);
    chk("bp.no_consume", 32'(lane_mask), 32'd0);

    // Flush of a partial word
    feed(4'hA); feed(4'h5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_word("flush", 16'h005A, 4'b0011, 3'd2);
    step();
    chk("flush.valid_drop", 32'(out_valid), 32'd0);

    // Flush coinciding with an accepted sample
    feed(4'h2); feed(4'h4);
    flush = 1'b1;
    feed(4'h6);
    flush = 1'b0;
    chk_word("flush_smp", 16'h0642, 4'b0111, 3'd3);
    step();

    // Flush on an empty packer is ignored
    flush = 1'b1;
    step();
    chk("flush_empty.valid0", 32'(out_valid), 32'd0);
    step();
    flush = 1'b0;
    chk("flush_empty.valid1", 32'(out_valid), 32'd0);
    chk("flush_empty.mask", 32'(lane_mask), 32'd0);

    // Bubbles in the input stream
    feed(4'h1); step(); step();
    feed(4'h2); feed(4'h3); step();
    chk("bub.not_yet", 32'(out_valid), 32'd0);
    chk("bub.partial_mask", 32'(lane_mask), 32'b0111);
    feed(4'h4);
    chk_word("bub", 16'h4321, 4'hF, 3'd4);
    step();

    // Reset mid-fill discards the partial word
    feed(4'hF); feed(4'hE);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_fill.valid", 32'(out_valid), 32'd0);
    chk("rst_fill.mask", 32'(lane_mask), 32'd0);
    feed(4'h1); feed(4'h2); feed(4'h3);
    chk("rst_fill.not_yet", 32'(out_valid), 32'd0);
    feed(4'h4);
    chk_word("rst_fill", 16'h4321, 4'hF, 3'd4);

    // Reset while holding drops the word
    out_ready = 1'b0;
    step();
    chk("rst_hold.still", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_hold.valid", 32'(out_valid), 32'd0);
    chk("rst_hold.values", 32'(lane_values), 32'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_packer.md
Name: lane_packer

Overview:
- Serial-to-parallel front end for the 4-lane max reduction path.
- Accepts a stream of WIDTH-bit samples with a valid/ready handshake and assembles them into one packed 4-lane word.
- Presents the packed word on a valid/ready output whose lane_values bus connects directly to the max-reduction block's lane_values input.
- Supports an early flush that emits a partially filled word, zero-padded, with a lane mask.

Parameters:
- WIDTH, 4, bit width of each sample/lane. Must be >= 1.
- NUM_LANES is a fixed localparam of 4 and cannot be overridden.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_value  input  WIDTH  incoming sample.
- in_valid  input  1  in_value is valid this cycle.
- in_ready  output  1  packer can accept a sample this cycle.
- flush  input  1  emit the current partial word (sampled only in FILL).
- lane_values  output  4*WIDTH  packed word; lane i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- lane_mask  output  4  bit i = 1 when lane i holds a real sample.
- lane_count  output  3  number of real lanes in the word, 1..4.
- out_valid  output  1  packed word is valid.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset values (synchronous, at the first rising edge with reset=1):
  - state=FILL, write index=0.
  - lane_values=0, lane_mask=0, lane_count=0, out_valid=0.
  - in_ready=0 while reset is high.
- States: FILL and HOLD. The state register and all outputs are registered, except in_ready.
- in_ready: combinational, equal to (state==FILL) && !reset. It does not depend on in_valid.
- FILL:
  - On in_valid && in_ready, in_value is written to lane[idx], mask bit idx is set, and idx increments. Lane 0 is filled first.
  - When the accepted sample lands in lane 3, the next state is HOLD and out_valid=1 on the following cycle, with lane_count=4 and lane_mask=4'b1111.
  - Gaps in in_valid have no effect; the partial word is retained indefinitely.
- flush in FILL:
  - If idx>0, or a sample is accepted the same cycle, go to HOLD next cycle.
  - A sample accepted in the flush cycle is included in the emitted word.
  - Unfilled lanes read as zero.
  - lane_count equals the number of filled lanes; lane_mask has its low lane_count bits set.
  - flush with idx==0 and no accept is ignored.
  - flush coinciding with the 4th sample produces a normal full word.
- HOLD:
  - in_ready=0. lane_values, lane_mask and lane_count are held stable while out_valid=1 and out_ready=0.
  - flush is ignored.
  - On out_valid && out_ready: next cycle out_valid=0, lane_values cleared to 0, mask and count cleared, idx=0, state=FILL.
- Latency: out_valid rises 1 cycle after the accept that completes the word, or 1 cycle after the flush cycle.
- Throughput: best case is one word per 5 cycles (4 accepts plus 1 handshake cycle). No overlap of fill and hold.
- Reset mid-operation: any partial or held word is discarded with no output. The first word after reset contains only post-reset samples.
- out_ready asserted while out_valid=0 has no effect.
- The downstream max-reduction block consumes lane_values as it sees them. Zero-padded lanes are neutral for an unsigned max, so no qualification is needed there.

Decomposition:
- Shared package holds:
  - NUM_LANES = 4
  - LANE_IDX_W = 2
  - LANE_CNT_W = 3
  - the two-value state enum (FILL, HOLD)
- The max-reduction block reuses NUM_LANES from the same package.
- No sub-module. Lane write logic is a generate loop over NUM_LANES with per-lane write enables.

Test Plan:
- Full word: after reset, feed samples 3,9,1,7 back-to-back with out_ready=1 → one cycle later lane_values=16'h7193, lane_mask=4'hF, lane_count=4, out_valid=1 for exactly 1 cycle; in_ready returns to 1 the cycle after the handshake.
- Backpressure: same samples with out_ready=0 for 3 cycles, then 1 → word 16'h7193 held stable for 4 cycles of out_valid; in_ready=0 throughout; a sample driven during HOLD is not consumed.
- Flush partial: feed A, then 5, then flush alone → lane_values=16'h005A, lane_mask=4'b0011, lane_count=2.
- Flush with sample: feed 2,4, then 6 with flush in the same cycle → 16'h0642, mask 4'b0111, count 3. A flush with an empty packer and no in_valid produces no out_valid.
- Bubbles: feed 1,(gap 2 cycles),2,3,(gap 1),4 → single word 16'h4321, out_valid 1 cycle after sample 4.
- Reset mid-fill: feed F,E, assert reset 1 cycle, then feed 1,2,3,4 → only word seen is 16'h4321 with count 4. Reset during HOLD drops out_valid the next cycle.
